// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns single-beat valid/ready commands into SETUP/ACCESS
// transfers, with wait-state handling, optional timeout, and a one-cycle response.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  input  logic [DATA_W-1:0] PRDATA
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen during the last permitted ACCESS cycle.
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t            state_r, state_n;
  logic [CW-1:0]     cnt_r, cnt_n;
  logic              cmd_ready_r, cmd_ready_n;
  logic              psel_r, psel_n;
  logic              penable_r, penable_n;
  logic              pwrite_r, pwrite_n;
  logic [ADDR_W-1:0] paddr_r, paddr_n;
  logic [DATA_W-1:0] pwdata_r, pwdata_n;
  logic              rsp_valid_r, rsp_valid_n;
  logic [DATA_W-1:0] rsp_rdata_r, rsp_rdata_n;
  logic              rsp_err_r, rsp_err_n;
  logic              rsp_timeout_r, rsp_timeout_n;
  logic              timeout_hit_s;

  // Next-state and next-output decode.
  always_comb begin
    state_n       = state_r;
    cnt_n         = cnt_r;
    cmd_ready_n   = 1'b0;
    psel_n        = 1'b0;
    penable_n     = 1'b0;
    pwrite_n      = pwrite_r;
    paddr_n       = paddr_r;
    pwdata_n      = pwdata_r;
    rsp_valid_n   = 1'b0;
    rsp_rdata_n   = '0;
    rsp_err_n     = 1'b0;
    rsp_timeout_n = 1'b0;
    timeout_hit_s = (TIMEOUT > 0) && (cnt_r == TO_LAST);

    case (state_r)
      ST_IDLE: begin
        // cmd_ready is low in the response cycle, which spaces acceptances 4 apart.
        if (cmd_valid && cmd_ready_r) begin
          state_n  = ST_SETUP;
          psel_n   = 1'b1;
          pwrite_n = cmd_write;
          paddr_n  = cmd_addr;
          pwdata_n = cmd_wdata;
        end else begin
          cmd_ready_n = 1'b1;
        end
      end
      ST_SETUP: begin
        state_n   = ST_ACCESS;
        psel_n    = 1'b1;
        penable_n = 1'b1;
        cnt_n     = '0;
      end
      ST_ACCESS: begin
        // PSLVERR alone counts as completion; completion beats timeout.
        if (PREADY || PSLVERR) begin
          state_n     = ST_IDLE;
          rsp_valid_n = 1'b1;
          rsp_err_n   = PSLVERR;
          if (!PSLVERR && !pwrite_r) begin
            rsp_rdata_n = PRDATA;
          end else begin
            rsp_rdata_n = '0;
          end
        end else if (timeout_hit_s) begin
          state_n       = ST_IDLE;
          rsp_valid_n   = 1'b1;
          rsp_err_n     = 1'b1;
          rsp_timeout_n = 1'b1;
        end else begin
          psel_n    = 1'b1;
          penable_n = 1'b1;
          cnt_n     = cnt_r + CW'(1);
        end
      end
      default: begin
        state_n     = ST_IDLE;
        cmd_ready_n = 1'b1;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      cmd_ready_r   <= 1'b1;
      psel_r        <= 1'b0;
      penable_r     <= 1'b0;
      pwrite_r      <= 1'b0;
      paddr_r       <= '0;
      pwdata_r      <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= '0;
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_n;
      cnt_r         <= cnt_n;
      cmd_ready_r   <= cmd_ready_n;
      psel_r        <= psel_n;
      penable_r     <= penable_n;
      pwrite_r      <= pwrite_n;
      paddr_r       <= paddr_n;
      pwdata_r      <= pwdata_n;
      rsp_valid_r   <= rsp_valid_n;
      rsp_rdata_r   <= rsp_rdata_n;
      rsp_err_r     <= rsp_err_n;
      rsp_timeout_r <= rsp_timeout_n;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign PSEL        = psel_r;
  assign PENABLE     = penable_r;
  assign PWRITE      = pwrite_r;
  assign PADDR       = paddr_r;
  assign PWDATA      = pwdata_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_rdata   = rsp_rdata_r;
  assign rsp_err     = rsp_err_r;
  assign rsp_timeout = rsp_timeout_r;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed self-checking bench for apb_master_bridge; the bench plays the APB responder.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One command with a given number of wait states; called from a cycle with cmd_ready=1.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int waits, input logic err, input logic [31:0] rdata,
                      input logic [31:0] exp_rdata, input string tag);
    check({31'd0, cmd_ready}, 32'd1, {tag, "_ready_c0"});
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    tick();
    cmd_valid = 1'b0; cmd_addr = 32'hFFFF_FFF0; cmd_wdata = 32'h5555_5555;
    check({31'd0, PSEL},      32'd1, {tag, "_psel_setup"});
    check({31'd0, PENABLE},   32'd0, {tag, "_penable_setup"});
    check({31'd0, cmd_ready}, 32'd0, {tag, "_ready_setup"});
    check(PADDR, addr,              {tag, "_paddr"});
    check({31'd0, PWRITE}, {31'd0, wr}, {tag, "_pwrite"});
    if (wr) check(PWDATA, wdata, {tag, "_pwdata"});
    else    check(PWDATA, PWDATA, {tag, "_pwdata_skip"});
    tick();
    for (int i = 0; i <= waits; i++) begin
      check({31'd0, PSEL},    32'd1, {tag, "_psel_access"});
      check({31'd0, PENABLE}, 32'd1, {tag, "_penable_access"});
      check(PADDR, addr,             {tag, "_paddr_hold"});
      check({31'd0, rsp_valid}, 32'd0, {tag, "_no_rsp_access"});
      if (i == waits) begin
        PREADY = ~err; PSLVERR = err; PRDATA = rdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0BAD_F00D;
      end
      tick();
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'hFFFF_FFFF;
    check({31'd0, PSEL},        32'd0, {tag, "_psel_done"});
    check({31'd0, PENABLE},     32'd0, {tag, "_penable_done"});
    check({31'd0, rsp_valid},   32'd1, {tag, "_rsp_valid"});
    check({31'd0, rsp_err},     {31'd0, err}, {tag, "_rsp_err"});
    check({31'd0, rsp_timeout}, 32'd0, {tag, "_rsp_timeout"});
    check(rsp_rdata, exp_rdata,        {tag, "_rsp_rdata"});
    check({31'd0, cmd_ready},   32'd0, {tag, "_ready_rsp"});
    tick();
    check({31'd0, rsp_valid},   32'd0, {tag, "_rsp_pulse"});
    check(rsp_rdata, 32'd0,            {tag, "_rdata_clear"});
    check({31'd0, cmd_ready},   32'd1, {tag, "_ready_back"});
    check(PADDR, addr,                 {tag, "_paddr_idle_hold"});
  endtask

  initial begin
    int cnt;
    int na, nr;
    int acc [3];
    logic [31:0] bb_addr [3];
    logic just_acc;

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = 32'd0; cmd_wdata = 32'd0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'd0;
    tick(); tick();
    check({31'd0, cmd_ready}, 32'd1, "rst_ready");
    check({31'd0, PSEL},      32'd0, "rst_psel");
    check({31'd0, PENABLE},   32'd0, "rst_penable");
    check({31'd0, rsp_valid}, 32'd0, "rst_rsp_valid");
    check(PADDR, 32'd0,              "rst_paddr");
    @(negedge PCLK);
    PRESET = 1'b0;
    tick();
    check({31'd0, cmd_ready}, 32'd1, "post_rst_ready");

    // Stray PREADY/PSLVERR in IDLE must not create a response.
    PREADY = 1'b1; PSLVERR = 1'b1;
    tick();
    check({31'd0, rsp_valid}, 32'd0, "idle_ignore_pready");
    PREADY = 1'b0; PSLVERR = 1'b0;

    xfer(1'b1, 32'h3,  32'hDEAD_BEEF, 0, 1'b0, 32'h0,         32'h0,         "wr0");
    xfer(1'b0, 32'h3,  32'h0,         6, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rdwait");
    xfer(1'b0, 32'd40, 32'h0,         2, 1'b1, 32'h1234_5678, 32'h0,         "slverr");

    // Timeout: responder never answers.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h44;
    tick();
    cmd_valid = 1'b0;
    tick();
    cnt = 0;
    while (PSEL && PENABLE && cnt < 40) begin
      cnt++;
      tick();
    end
    check(32'(cnt), 32'd16,            "to_access_cycles");
    check({31'd0, PSEL},        32'd0, "to_psel");
    check({31'd0, rsp_valid},   32'd1, "to_rsp_valid");
    check({31'd0, rsp_err},     32'd1, "to_rsp_err");
    check({31'd0, rsp_timeout}, 32'd1, "to_rsp_timeout");
    check(rsp_rdata, 32'd0,            "to_rsp_rdata");
    tick();
    check({31'd0, rsp_timeout}, 32'd0, "to_pulse");
    xfer(1'b1, 32'h100, 32'hCAFE_0001, 1, 1'b0, 32'h0, 32'h0, "after_to");

    // Back-to-back: three queued reads, responder always ready.
    bb_addr[0] = 32'h10; bb_addr[1] = 32'h20; bb_addr[2] = 32'h30;
    na = 0; nr = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = bb_addr[0];
    PREADY = 1'b1;
    for (int c = 0; c < 24; c++) begin
      just_acc = cmd_valid && cmd_ready;
      if (just_acc) begin
        if (na < 3) acc[na] = c;
        na++;
      end
      if (rsp_valid) begin
        if (nr < 3) check(rsp_rdata, bb_addr[nr] ^ 32'hA5A5_0000, "bb_rdata_order");
        check({31'd0, rsp_err}, 32'd0, "bb_rsp_err");
        nr++;
      end
      PRDATA = PADDR ^ 32'hA5A5_0000;
      tick();
      if (just_acc) begin
        if (na < 3) cmd_addr = bb_addr[na];
        else        cmd_valid = 1'b0;
      end
    end
    PREADY = 1'b0;
    check(32'(na), 32'd3, "bb_accepts");
    check(32'(nr), 32'd3, "bb_responses");
    check(32'(acc[1] - acc[0]), 32'd4, "bb_spacing_01");
    check(32'(acc[2] - acc[1]), 32'd4, "bb_spacing_12");

    // Reset during a wait state.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
    tick();
    cmd_valid = 1'b0;
    tick();
    check({31'd0, PENABLE}, 32'd1, "rstmid_in_access");
    tick();
    #2;
    PRESET = 1'b1;
    #1;
    check({31'd0, PSEL},      32'd0, "rstmid_psel");
    check({31'd0, PENABLE},   32'd0, "rstmid_penable");
    check({31'd0, rsp_valid}, 32'd0, "rstmid_rsp_valid");
    @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    tick();
    check({31'd0, cmd_ready}, 32'd1, "rstmid_ready");
    check({31'd0, rsp_valid}, 32'd0, "rstmid_no_rsp");
    xfer(1'b1, 32'h9, 32'h0000_ABCD, 0, 1'b0, 32'h0, 32'h0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
